spi_cmd_sequencer: RTL and testbench
====================================

# spi_cmd_sequencer

Command-layer controller behind the FPGA SPI slave byte interface. Turns received byte strobes into register-file reads and writes with address auto-increment, and sequences the byte to shift out to the master on each following transfer. Sits between the SPI slave (rxData/rx_Valid in, txData/tx_Valid out) and the FPGA register bank.

## Interface
- ADDR_W, 7, register address width; also the command-byte address field width.
- STATUS_TAG, 4'hA, constant upper nibble of the status byte.

- sysClk  in  1  FPGA system clock; all logic on posedge.
- sysRst  in  1  asynchronous, active-high reset.
- SS  in  1  raw SPI slave select, active low; synchronized internally with 2 flops.
- rxData  in  8  received byte from SPI slave.
- rx_Valid  in  1  level from SPI slave; high while the last bit of a byte is being taken, may last many cycles.
- txData  out  8  byte presented to the SPI slave for the next transfer.
- tx_Valid  out  1  txData is meaningful; when low the slave shifts zeros.
- regAddr  out  ADDR_W  register bank address.
- regWrData  out  8  write data.
- regWe  out  1  one-cycle write strobe.
- regRe  out  1  one-cycle read strobe.
- regRdData  in  8  read data, valid exactly 1 cycle after regRe.
- txnCount  out  4  count of completed transactions, wraps 15->0.

## Operation
- Byte strobe: rxStb = rx_Valid & ~rx_Valid_d & ssActive. One strobe per byte however long rx_Valid stays high. ssActive is the synchronized, inverted SS.
- Command byte: first byte after SS falls. Bit 7 = 1 means write, 0 means read. Bits [ADDR_W-1:0] are the start address; with ADDR_W=7 that is bits 6:0.
- States: IDLE, CMD, WR, RD_ISSUE, RD_WAIT, RD_HOLD.
  - IDLE -> CMD when ssActive rises. txData = {STATUS_TAG, txnCount}, tx_Valid=1, so the master reads the status byte while it clocks the command.
  - CMD, on rxStb, latches addr. Write command -> WR. Read command -> RD_ISSUE.
  - WR, on rxStb: regWrData=rxData, regAddr=addr, regWe=1 for 1 cycle, then addr <= addr+1. tx_Valid=0 while in WR.
  - RD_ISSUE: regRe=1 with regAddr=addr for 1 cycle -> RD_WAIT.
  - RD_WAIT: txData <= regRdData, tx_Valid=1, addr <= addr+1 -> RD_HOLD.
  - RD_HOLD, on rxStb -> RD_ISSUE. The data bytes the master sends during a read are ignored.
- Any state, ssActive falls (SS rises): -> IDLE and tx_Valid=0. An in-flight regRe/regWe strobe already issued still completes; no new strobe is issued. txnCount increments only if the command byte was received.
- Address arithmetic: addr is ADDR_W bits and increments modulo 2^ADDR_W; 7'h7F wraps to 7'h00.
- rxStb while in RD_ISSUE or RD_WAIT is a protocol overrun. The byte is dropped and the state proceeds normally; no strobe is lost or duplicated.

## Timing
- Reset values: txData=8'h00, tx_Valid=0, regAddr=0, regWrData=0, regWe=0, regRe=0, txnCount=0, state IDLE, addr=0, sync flops = 1 (SS inactive).
- SS sync latency: 2 cycles. The status byte is valid at most 3 cycles after SS falls.
- Write: regWe asserts on the cycle after rxStb, which is 2 cycles after the rx_Valid rising edge. regAddr and regWrData are stable that same cycle.
- Read: rxStb at cycle N gives regRe at N+1, RD_WAIT at N+2, and txData/tx_Valid updated at N+3.
- Requirement on the SPI side: SPICLK half-period ≥ 4 sysClk, so the read byte is ready before the next transfer's first shift.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronous). After release, the block waits in IDLE for a fresh SS falling edge, even if SS is still low.

## Test plan
- Reset, then SS low: txData=8'hA0, tx_Valid=1 within 3 cycles; all strobes stay 0.
- Write burst: SS low, bytes 8'h85, 8'h11, 8'h22, SS high -> regWe pulses twice: addr 0x05 data 0x11, then addr 0x06 data 0x22; txnCount=1.
- Read burst with regRdData = addr^8'h5A: bytes 8'h10, 8'hFF, 8'hFF -> regRe at 0x10 then 0x11. txData is 8'h4A before the 2nd transfer and 8'h4B before the 3rd.
- Wrap: write command 8'hFF followed by 2 data bytes -> writes at 0x7F then 0x00.
- rx_Valid held high for 20 cycles on one byte -> exactly one regWe; SS raised mid-byte -> IDLE, tx_Valid=0, no further strobes.
- Async reset pulse during RD_WAIT -> outputs are reset values in the same cycle; a following transaction returns status 8'hA0 because txnCount was reset.

Source files
------------

// File: rtl/spi_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// spi_cmd_sequencer
//
// Command layer behind the SPI slave byte interface. The first byte after
// SS falls is a command (bit 7 = write, low bits = start address); following
// bytes are written to consecutive registers, or, for a read command, the
// sequencer fetches consecutive registers and presents each one to the SPI
// slave ahead of the next transfer.
//
// State   | meaning
// --------+------------------------------------------------------------------
// IDLE    | no transaction; waits for a fresh SS falling edge
// CMD     | status byte presented, waiting for the command byte
// WR      | each received byte is written, address increments
// RD_ISSUE| regRe strobe is on the bus this cycle
// RD_WAIT | regRdData valid; capture into txData, address increments
// RD_HOLD | read byte presented, waiting for the master's next byte
//
// Ports
//   sysClk     system clock, all logic on posedge
//   sysRst     asynchronous active-high reset
//   SS         raw SPI slave select (active low), synchronized internally
//   rxData     received byte from the SPI slave
//   rx_Valid   byte-complete level from the SPI slave (may stay high long)
//   txData     byte for the next transfer
//   tx_Valid   txData is meaningful (slave shifts zeros when low)
//   regAddr    register bank address
//   regWrData  register write data
//   regWe      one-cycle write strobe
//   regRe      one-cycle read strobe
//   regRdData  read data, valid one cycle after regRe
//   txnCount   completed transactions, wraps 15 -> 0
// -----------------------------------------------------------------------------
module spi_cmd_sequencer #(
    parameter int          ADDR_W     = 7,
    parameter logic [3:0]  STATUS_TAG = 4'hA
) (
    input  logic              sysClk,
    input  logic              sysRst,
    input  logic              SS,
    input  logic [7:0]        rxData,
    input  logic              rx_Valid,
    output logic [7:0]        txData,
    output logic              tx_Valid,
    output logic [ADDR_W-1:0] regAddr,
    output logic [7:0]        regWrData,
    output logic              regWe,
    output logic              regRe,
    input  logic [7:0]        regRdData,
    output logic [3:0]        txnCount
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CMD      = 3'd1,
        WR       = 3'd2,
        RD_ISSUE = 3'd3,
        RD_WAIT  = 3'd4,
        RD_HOLD  = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_t state, state_n;

    logic              ss_sync1, ss_sync2;
    logic [1:0]        sync_fill;
    logic              armed;
    logic              ss_active, ss_active_d, ss_rise;
    logic              rx_valid_q, rx_valid_d, rx_stb;

    logic [ADDR_W-1:0] addr, addr_n;
    logic              cmd_seen, cmd_seen_n;
    logic [7:0]        tx_data_n;
    logic              tx_valid_n;
    logic [ADDR_W-1:0] reg_addr_n;
    logic [7:0]        reg_wr_data_n;
    logic              reg_we_n, reg_re_n;
    logic [3:0]        txn_count_n;

    // SS synchronizer. Reset loads the inactive level, so the flops alone
    // cannot tell a held-low SS from a new edge after reset; sync_fill marks
    // when the pipeline holds real samples, and armed requires SS to have been
    // seen inactive after that before any edge is accepted.
    always_ff @(posedge sysClk or posedge sysRst) begin
        if (sysRst) begin
            ss_sync1    <= 1'b1;
            ss_sync2    <= 1'b1;
            sync_fill   <= 2'b00;
            armed       <= 1'b0;
            ss_active_d <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_valid_d  <= 1'b0;
        end else begin
            ss_sync1    <= SS;
            ss_sync2    <= ss_sync1;
            sync_fill   <= {sync_fill[0], 1'b1};
            if (sync_fill[1] && ss_sync2)
                armed <= 1'b1;
            ss_active_d <= ss_active;
            rx_valid_q  <= rx_Valid;
            rx_valid_d  <= rx_valid_q;
        end
    end

    assign ss_active = ~ss_sync2;
    assign ss_rise   = ss_active & ~ss_active_d & armed;
    assign rx_stb    = rx_valid_q & ~rx_valid_d & ss_active;

    always_ff @(posedge sysClk or posedge sysRst) begin
        if (sysRst) begin
            state     <= IDLE;
            addr      <= '0;
            cmd_seen  <= 1'b0;
            txData    <= 8'h00;
            tx_Valid  <= 1'b0;
            regAddr   <= '0;
            regWrData <= 8'h00;
            regWe     <= 1'b0;
            regRe     <= 1'b0;
            txnCount  <= 4'd0;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            cmd_seen  <= cmd_seen_n;
            txData    <= tx_data_n;
            tx_Valid  <= tx_valid_n;
            regAddr   <= reg_addr_n;
            regWrData <= reg_wr_data_n;
            regWe     <= reg_we_n;
            regRe     <= reg_re_n;
            txnCount  <= txn_count_n;
        end
    end

    always_comb begin
        state_n       = state;
        addr_n        = addr;
        cmd_seen_n    = cmd_seen;
        tx_data_n     = txData;
        tx_valid_n    = tx_Valid;
        reg_addr_n    = regAddr;
        reg_wr_data_n = regWrData;
        reg_we_n      = 1'b0;
        reg_re_n      = 1'b0;
        txn_count_n   = txnCount;

        if (state == IDLE) begin
            if (ss_rise) begin
                tx_data_n  = {STATUS_TAG, txnCount};
                tx_valid_n = 1'b1;
                cmd_seen_n = 1'b0;
                state_n    = CMD;
            end
        end else if (!ss_active) begin
            // Aborts from any state; a strobe already registered still
            // completes because the strobe registers simply fall next cycle.
            state_n    = IDLE;
            tx_valid_n = 1'b0;
            cmd_seen_n = 1'b0;
            if (cmd_seen)
                txn_count_n = txnCount + 4'd1;
        end else begin
            case (state)
                CMD: begin
                    if (rx_stb) begin
                        addr_n     = rxData[ADDR_W-1:0];
                        cmd_seen_n = 1'b1;
                        if (rxData[7]) begin
                            tx_valid_n = 1'b0;
                            state_n    = WR;
                        end else begin
                            reg_re_n   = 1'b1;
                            reg_addr_n = rxData[ADDR_W-1:0];
                            state_n    = RD_ISSUE;
                        end
                    end
                end
                WR: begin
                    if (rx_stb) begin
                        reg_we_n      = 1'b1;
                        reg_wr_data_n = rxData;
                        reg_addr_n    = addr;
                        addr_n        = addr + ADDR_ONE;
                    end
                end
                // Strobes landing in RD_ISSUE/RD_WAIT are overruns and dropped.
                RD_ISSUE: state_n = RD_WAIT;
                RD_WAIT: begin
                    tx_data_n  = regRdData;
                    tx_valid_n = 1'b1;
                    addr_n     = addr + ADDR_ONE;
                    state_n    = RD_HOLD;
                end
                RD_HOLD: begin
                    if (rx_stb) begin
                        reg_re_n   = 1'b1;
                        reg_addr_n = addr;
                        state_n    = RD_ISSUE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
module tb_spi_cmd_sequencer;

    logic       sysClk = 1'b0;
    logic       sysRst;
    logic       SS;
    logic [7:0] rxData;
    logic       rx_Valid;
    logic [7:0] txData;
    logic       tx_Valid;
    logic [6:0] regAddr;
    logic [7:0] regWrData;
    logic       regWe;
    logic       regRe;
    logic [7:0] regRdData;
    logic [3:0] txnCount;

    int checks = 0;
    int errors = 0;

    // Register bank model and strobe log.
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    logic [6:0] wr_addr [0:31];
    logic [7:0] wr_data [0:31];
    logic [6:0] rd_addr [0:31];

    spi_cmd_sequencer #(.ADDR_W(7), .STATUS_TAG(4'hA)) dut (
        .sysClk    (sysClk),
        .sysRst    (sysRst),
        .SS        (SS),
        .rxData    (rxData),
        .rx_Valid  (rx_Valid),
        .txData    (txData),
        .tx_Valid  (tx_Valid),
        .regAddr   (regAddr),
        .regWrData (regWrData),
        .regWe     (regWe),
        .regRe     (regRe),
        .regRdData (regRdData),
        .txnCount  (txnCount)
    );

    always #5 sysClk = ~sysClk;

    always @(posedge sysClk) begin
        if (regRe) begin
            regRdData          <= {1'b0, regAddr} ^ 8'h5A;
            rd_addr[rd_cnt%32] <= regAddr;
            rd_cnt             <= rd_cnt + 1;
        end
        if (regWe) begin
            wr_addr[wr_cnt%32] <= regAddr;
            wr_data[wr_cnt%32] <= regWrData;
            wr_cnt             <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sysClk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rxData   = b;
        rx_Valid = 1'b1;
        tick(4);
        rx_Valid = 1'b0;
        tick(4);
    endtask

    initial begin
        sysRst    = 1'b1;
        SS        = 1'b1;
        rxData    = 8'h00;
        rx_Valid  = 1'b0;
        regRdData = 8'h00;
        tick(2);
        check("rst_txData",    {24'd0, txData},    32'h00);
        check("rst_tx_Valid",  {31'd0, tx_Valid},  32'h0);
        check("rst_regAddr",   {25'd0, regAddr},   32'h00);
        check("rst_regWrData", {24'd0, regWrData}, 32'h00);
        check("rst_strobes",   {30'd0, regWe, regRe}, 32'h0);
        check("rst_txnCount",  {28'd0, txnCount},  32'h0);
        sysRst = 1'b0;
        tick(4);

        // Status byte after SS falls
        SS = 1'b0;
        tick(3);
        check("status_txData",   {24'd0, txData},   32'hA0);
        check("status_tx_Valid", {31'd0, tx_Valid}, 32'h1);
        check("status_no_strobes", wr_cnt + rd_cnt, 0);

        // Write burst 85 11 22
        tick(1);
        send_byte(8'h85);
        check("wr_tx_Valid_low", {31'd0, tx_Valid}, 32'h0);
        rxData   = 8'h11;
        rx_Valid = 1'b1;
        tick(1);
        check("wr_we_not_early", {31'd0, regWe}, 32'h0);
        tick(1);
        check("wr_we_timing", {31'd0, regWe}, 32'h1);
        check("wr_addr_timing", {25'd0, regAddr}, 32'h05);
        check("wr_data_timing", {24'd0, regWrData}, 32'h11);
        tick(2);
        rx_Valid = 1'b0;
        tick(4);
        send_byte(8'h22);
        SS = 1'b1;
        tick(4);
        check("wr_count", wr_cnt, 2);
        check("wr0_addr", {25'd0, wr_addr[0]}, 32'h05);
        check("wr1_addr", {25'd0, wr_addr[1]}, 32'h06);
        check("wr1_data", {24'd0, wr_data[1]}, 32'h22);
        check("wr_txnCount", {28'd0, txnCount}, 32'h1);
        check("wr_end_tx_Valid", {31'd0, tx_Valid}, 32'h0);

        // Read burst 10 FF FF
        SS = 1'b0;
        tick(4);
        check("rd_status", {24'd0, txData}, 32'hA1);
        send_byte(8'h10);
        check("rd_byte1", {24'd0, txData}, 32'h4A);
        check("rd_byte1_valid", {31'd0, tx_Valid}, 32'h1);
        check("rd0_addr", {25'd0, rd_addr[0]}, 32'h10);
        send_byte(8'hFF);
        check("rd_byte2", {24'd0, txData}, 32'h4B);
        check("rd1_addr", {25'd0, rd_addr[1]}, 32'h11);
        send_byte(8'hFF);
        SS = 1'b1;
        tick(4);
        check("rd_count", rd_cnt, 3);
        check("rd_no_writes", wr_cnt, 2);
        check("rd_txnCount", {28'd0, txnCount}, 32'h2);

        // Address wrap
        SS = 1'b0;
        tick(4);
        send_byte(8'hFF);
        send_byte(8'hAA);
        send_byte(8'hBB);
        SS = 1'b1;
        tick(4);
        check("wrap_count", wr_cnt, 4);
        check("wrap_addr0", {25'd0, wr_addr[2]}, 32'h7F);
        check("wrap_data0", {24'd0, wr_data[2]}, 32'hAA);
        check("wrap_addr1", {25'd0, wr_addr[3]}, 32'h00);
        check("wrap_data1", {24'd0, wr_data[3]}, 32'hBB);
        check("wrap_txnCount", {28'd0, txnCount}, 32'h3);

        // Long rx_Valid, then SS raised mid-byte
        SS = 1'b0;
        tick(4);
        send_byte(8'h83);
        rxData   = 8'h5C;
        rx_Valid = 1'b1;
        tick(20);
        check("long_one_we", wr_cnt, 5);
        check("long_addr", {25'd0, wr_addr[4]}, 32'h03);
        check("long_data", {24'd0, wr_data[4]}, 32'h5C);
        SS = 1'b1;
        tick(4);
        rx_Valid = 1'b0;
        tick(2);
        rx_Valid = 1'b1;
        tick(4);
        rx_Valid = 1'b0;
        tick(2);
        check("abort_no_strobes", wr_cnt + rd_cnt, 8);
        check("abort_tx_Valid", {31'd0, tx_Valid}, 32'h0);
        check("abort_txnCount", {28'd0, txnCount}, 32'h4);

        // Async reset during RD_WAIT
        SS = 1'b0;
        tick(4);
        rxData   = 8'h20;
        rx_Valid = 1'b1;
        tick(3);
        #2;
        sysRst = 1'b1;
        #1;
        check("arst_txData",   {24'd0, txData},   32'h00);
        check("arst_tx_Valid", {31'd0, tx_Valid}, 32'h0);
        check("arst_regAddr",  {25'd0, regAddr},  32'h00);
        check("arst_strobes",  {30'd0, regWe, regRe}, 32'h0);
        check("arst_txnCount", {28'd0, txnCount}, 32'h0);
        rx_Valid = 1'b0;
        tick(2);
        sysRst = 1'b0;
        tick(6);
        check("arst_wait_fresh_ss", {31'd0, tx_Valid}, 32'h0);
        SS = 1'b1;
        tick(4);
        SS = 1'b0;
        tick(4);
        check("arst_status", {24'd0, txData}, 32'hA0);
        check("arst_status_valid", {31'd0, tx_Valid}, 32'h1);
        SS = 1'b1;
        tick(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
